// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for the fetch stage.
// Computes the next PC from pcsel, protects the supervisor bit on all
// arithmetic and jumps, tracks multi-cycle instructions, and resolves a
// latched interrupt request at instruction boundaries.
module pc_seq #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MULTI_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h8000_0000),
  parameter logic [ADDR_W-1:0] ILLOP_VEC = ADDR_W'(32'h8000_0004),
  parameter logic [ADDR_W-1:0] XADR_VEC  = ADDR_W'(32'h8000_0008)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        id,
  input  logic [ADDR_W-1:0]  jt,
  input  logic [2:0]         pcsel,
  input  logic [MULTI_W-1:0] multi,
  input  logic               stall,
  input  logic               irq,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_inc,
  output logic [ADDR_W-1:0]  pc_offset,
  output logic [MULTI_W-1:0] multi_counter,
  output logic               irq_take
);

  // Low (non-supervisor) PC width; arithmetic wraps within it.
  localparam int unsigned LOW_W = ADDR_W - 1;
  // Branch offset is built at least wide enough to hold id << 2 plus a sign bit.
  localparam int unsigned EXT_W = (LOW_W > 19) ? LOW_W : 19;
  localparam int unsigned REP_W = EXT_W - 18;

  localparam logic [2:0] SEL_INC  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_JMP  = 3'd2;
  localparam logic [2:0] SEL_XADR = 3'd4;

  logic               irq_pend;
  logic               sup_bit;
  logic               at_boundary;
  logic [EXT_W-1:0]   id_shift;
  logic [EXT_W-1:0]   offset_sum;
  logic [ADDR_W-1:0]  jmp_target;
  logic [ADDR_W-1:0]  pc_d;
  logic [MULTI_W-1:0] cnt_d;
  logic               pend_d;
  logic               unused_jt_bits;

  assign unused_jt_bits = ^jt[1:0];

  // State register: PC, multi-cycle counter and pending interrupt latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_VEC;
      multi_counter <= '0;
      irq_pend      <= 1'b0;
    end else begin
      pc            <= pc_d;
      multi_counter <= cnt_d;
      irq_pend      <= pend_d;
    end
  end

  // Next-state selection; the interrupt redirect outranks only pcsel=0.
  always_comb begin
    pc_d       = pc;
    cnt_d      = multi_counter;
    pend_d     = irq_pend | irq;
    jmp_target = {sup_bit & jt[ADDR_W-1], jt[ADDR_W-2:2], 2'b00};
    if (!stall) begin
      if (irq_take) begin
        pc_d   = XADR_VEC;
        cnt_d  = '0;
        pend_d = 1'b0;
      end else begin
        unique case (pcsel)
          SEL_INC: begin
            if (at_boundary) begin
              pc_d  = pc_inc;
              cnt_d = '0;
            end else begin
              cnt_d = multi_counter + MULTI_W'(1);
            end
          end
          SEL_BR: begin
            pc_d  = pc_offset;
            cnt_d = '0;
          end
          SEL_JMP: begin
            pc_d  = jmp_target;
            cnt_d = '0;
          end
          SEL_XADR: begin
            pc_d  = XADR_VEC;
            cnt_d = '0;
          end
          default: begin
            pc_d  = ILLOP_VEC;
            cnt_d = '0;
          end
        endcase
      end
    end
  end

  // Combinational outputs: supervisor-preserving PC arithmetic and interrupt take.
  always_comb begin
    sup_bit     = pc[ADDR_W-1];
    at_boundary = (multi_counter >= multi);
    id_shift    = {{REP_W{id[15]}}, id, 2'b00};
    pc_inc      = {sup_bit, pc[LOW_W-1:0] + LOW_W'(4)};
    offset_sum  = EXT_W'(pc_inc[LOW_W-1:0]) + id_shift;
    pc_offset   = {sup_bit, offset_sum[LOW_W-1:0]};
    irq_take    = !reset && (irq_pend || irq) && !sup_bit && !stall &&
                  (pcsel == SEL_INC) && at_boundary;
  end

endmodule
